// File: rtl/controller.sv
// Multicycle control unit: Moore main FSM, ALU decode, NZCV flag register and write-strobe gating.
// Outputs depend only on state, stored flags, condex_q and Instr; reset forces FETCH outputs with strobes low.
module controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    state_t     state;
    state_t     cur;
    logic [3:0] flags;
    logic       condex_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       cond_ok;
    logic       no_write;
    logic [1:0] flag_w;
    logic [2:0] dp_alu;
    logic       next_pc, branch, reg_w, mem_w;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign cmd   = funct[4:1];

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flags[2];
            4'b0001: cond_ok = ~flags[2];
            4'b0010: cond_ok = flags[1];
            4'b0011: cond_ok = ~flags[1];
            4'b0100: cond_ok = flags[3];
            4'b0101: cond_ok = ~flags[3];
            4'b0110: cond_ok = flags[0];
            4'b0111: cond_ok = ~flags[0];
            4'b1000: cond_ok = flags[1] & ~flags[2];
            4'b1001: cond_ok = ~flags[1] | flags[2];
            4'b1010: cond_ok = (flags[3] == flags[0]);
            4'b1011: cond_ok = (flags[3] != flags[0]);
            4'b1100: cond_ok = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ok = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Unrecognised commands execute as ADD but never write the register file.
    always_comb begin
        dp_alu   = 3'b000;
        no_write = 1'b0;
        case (cmd)
            4'b0100: dp_alu = 3'b000;
            4'b0010: dp_alu = 3'b001;
            4'b0000: dp_alu = 3'b010;
            4'b1100: dp_alu = 3'b011;
            4'b1010: begin dp_alu = 3'b001; no_write = 1'b1; end
            default: begin dp_alu = 3'b000; no_write = 1'b1; end
        endcase
        if (op != 2'b00)
            no_write = 1'b0;
        flag_w[1] = funct[0];
        flag_w[0] = funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            flags    <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    condex_q <= cond_ok;
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR:   state <= funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                EXECR, EXECI: begin
                    state <= ALUWB;
                    if (flag_w[1] & condex_q) flags[3:2] <= ALUFlags[3:2];
                    if (flag_w[0] & condex_q) flags[1:0] <= ALUFlags[1:0];
                end
                default: state <= FETCH;
            endcase
        end
    end

    // During reset the outputs present FETCH values with every strobe held low.
    assign cur = reset ? FETCH : state;

    always_comb begin
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        case (cur)
            FETCH: begin
                IRWrite = ~reset; next_pc = ~reset;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB:    begin ResultSrc = 2'b01; reg_w = 1'b1; end
            MEMWRITE: begin AdrSrc = 1'b1; mem_w = 1'b1; end
            EXECR:    ALUControl = dp_alu;
            EXECI:    begin ALUSrcB = 2'b01; ALUControl = dp_alu; end
            ALUWB:    reg_w = 1'b1;
            BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
            default:  ;
        endcase
        PCWrite  = next_pc | (branch & condex_q);
        RegWrite = reg_w & condex_q & ~no_write;
        MemWrite = mem_w & condex_q;
        RegSrc   = {op == 2'b01, op == 2'b10};
        ImmSrc   = op;
    end
endmodule
